// File: rtl/radio_pll_responder_if.sv
// Lane bundle between the timing engine and the radio/PLL responder.
// PLL_RELOCK_EN adds the per-lane lockLoss request.
interface radio_pll_responder_if #(
  parameter int BIT_WIDTH = 2
);
  logic [BIT_WIDTH-1:0] radioEnable;
  logic [BIT_WIDTH-1:0] radioRxEn;
  logic [BIT_WIDTH-1:0] pllSettled;
  logic [BIT_WIDTH-1:0] tArstFs;
  logic                 busy;
`ifdef PLL_RELOCK_EN
  logic [BIT_WIDTH-1:0] lockLoss;

  modport master (
    output radioEnable,
    output radioRxEn,
    output lockLoss,
    input  pllSettled,
    input  tArstFs,
    input  busy
  );

  modport slave (
    input  radioEnable,
    input  radioRxEn,
    input  lockLoss,
    output pllSettled,
    output tArstFs,
    output busy
  );
`else
  modport master (
    output radioEnable,
    output radioRxEn,
    input  pllSettled,
    input  tArstFs,
    input  busy
  );

  modport slave (
    input  radioEnable,
    input  radioRxEn,
    output pllSettled,
    output tArstFs,
    output busy
  );
`endif
endinterface

// File: rtl/radio_pll_responder.sv
// Radio/PLL-side responder: one OFF/SETTLING/LOCKED/RX FSM per lane.
// Define PLL_RELOCK_EN to enable lockLoss-driven relock.
module radio_pll_responder #(
  parameter int BIT_WIDTH     = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int RX_TIMEOUT    = 16,
  parameter int CNT_W         = 5
) (
  input logic                  ck,
  input logic                  arst,
  input logic                  isolate,
  radio_pll_responder_if.slave bus
);

  typedef enum logic [1:0] {
    OFF,
    SETTLING,
    LOCKED,
    RX
  } state_t;

  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RX_LAST =
    CNT_W'(RX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               st_q   [BIT_WIDTH];
  state_t               st_d   [BIT_WIDTH];
  logic [CNT_W-1:0]     cnt_q  [BIT_WIDTH];
  logic [CNT_W-1:0]     cnt_d  [BIT_WIDTH];
  logic [CNT_W-1:0]     cnt_inc[BIT_WIDTH];
  logic [BIT_WIDTH-1:0] en;
  logic [BIT_WIDTH-1:0] rx;
  logic [BIT_WIDTH-1:0] lost;
  logic [BIT_WIDTH-1:0] strobe_d;
  logic [BIT_WIDTH-1:0] settled_d;
  logic [BIT_WIDTH-1:0] active_d;

  // Isolation only masks the requests; lanes then fall out via en=0.
  assign en = bus.radioEnable & ~{BIT_WIDTH{isolate}};
  assign rx = bus.radioRxEn & ~{BIT_WIDTH{isolate}};

`ifdef PLL_RELOCK_EN
  assign lost = bus.lockLoss;
`else
  assign lost = '0;
`endif

  always_comb begin
    for (int i = 0; i < BIT_WIDTH; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (cnt_q[i] != CNT_MAX) begin
        cnt_inc[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < BIT_WIDTH; i++) begin
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      strobe_d[i] = 1'b0;
      unique case (st_q[i])
        OFF: begin
          if (en[i]) begin
            st_d[i]  = SETTLING;
            cnt_d[i] = '0;
          end
        end
        SETTLING: begin
          if (!en[i]) begin
            st_d[i]     = OFF;
            strobe_d[i] = 1'b1;
          end else if (cnt_q[i] == SET_LAST) begin
            st_d[i] = LOCKED;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        LOCKED: begin
          if (!en[i]) begin
            st_d[i] = OFF;
          end else if (lost[i]) begin
            st_d[i]     = SETTLING;
            cnt_d[i]    = '0;
            strobe_d[i] = 1'b1;
          end else if (rx[i]) begin
            st_d[i]  = RX;
            cnt_d[i] = '0;
          end
        end
        RX: begin
          if (!en[i]) begin
            st_d[i] = OFF;
          end else if (lost[i]) begin
            st_d[i]     = SETTLING;
            cnt_d[i]    = '0;
            strobe_d[i] = 1'b1;
          end else if (!rx[i]) begin
            st_d[i] = LOCKED;
          end else if (cnt_q[i] == RX_LAST) begin
            st_d[i]     = LOCKED;
            strobe_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        default: begin
          st_d[i]  = OFF;
          cnt_d[i] = '0;
        end
      endcase
      settled_d[i] = (st_d[i] == LOCKED) ||
                     (st_d[i] == RX);
      active_d[i]  = (st_d[i] != OFF);
    end
  end

  // Outputs are registered from the next state.
  always_ff @(posedge ck) begin
    if (arst) begin
      for (int i = 0; i < BIT_WIDTH; i++) begin
        st_q[i]  <= OFF;
        cnt_q[i] <= '0;
      end
      bus.pllSettled <= '0;
      bus.tArstFs    <= '0;
      bus.busy       <= 1'b0;
    end else begin
      for (int i = 0; i < BIT_WIDTH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      bus.pllSettled <= settled_d;
      bus.tArstFs    <= strobe_d;
      bus.busy       <= |active_d;
    end
  end

endmodule
